// File: rtl/adxl345_spi_reader.sv
// SPI mode-3 master for the ADXL345: two configuration writes after a startup delay, then
// periodic 6-byte burst reads of DATAX0..DATAZ1 presented as signed 16-bit samples.
module adxl345_spi_reader #(
    parameter int unsigned CLK_DIV        = 25,
    parameter int unsigned SAMPLE_PERIOD  = 500000,
    parameter int unsigned STARTUP_CYCLES = 100000
) (
    input  logic        MAX10_CLK1_50,
    input  logic        rst_n,
    output logic        spi_cs_n,
    output logic        spi_sclk,
    output logic        spi_sdi,
    input  logic        spi_sdo,
    output logic [15:0] accel_x,
    output logic [15:0] accel_y,
    output logic [15:0] accel_z,
    output logic        data_valid,
    output logic        init_done,
    output logic        busy
);

    typedef enum logic [2:0] {StStartup, StWrPwr, StWrFmt, StIdle, StRd} state_e;

    localparam logic [31:0] DivLast     = 32'(CLK_DIV - 1);
    localparam logic [31:0] StartLast   = 32'(STARTUP_CYCLES);
    localparam logic [31:0] PeriodLast  = 32'(SAMPLE_PERIOD - 1);
    localparam logic [6:0]  WrLastPhase = 7'd33;
    localparam logic [6:0]  RdLastPhase = 7'd113;

    state_e      state_q, state_d;
    logic        cs_n_q, cs_n_d;
    logic        sclk_q, sclk_d;
    logic        sdi_q, sdi_d;
    logic [31:0] cnt_q, cnt_d;      // startup delay, then cs_n high time
    logic [31:0] timer_q, timer_d;  // cycles since last read start
    logic [31:0] div_q, div_d;
    logic [6:0]  phase_q, phase_d;  // 0 setup, odd = SCLK low, even = SCLK high, last = hold
    logic [15:0] tx_q, tx_d;
    logic [47:0] rx_q, rx_d;
    logic [15:0] x_q, x_d, y_q, y_d, z_q, z_d;
    logic        dv_q, dv_d;
    logic        init_q, init_d;
    logic        start;
    logic [15:0] start_word;
    logic [6:0]  last_phase;

    always_comb begin
        state_d    = state_q;
        cs_n_d     = cs_n_q;
        sclk_d     = sclk_q;
        sdi_d      = sdi_q;
        cnt_d      = cnt_q;
        timer_d    = (timer_q == '1) ? timer_q : timer_q + 32'd1;
        div_d      = div_q;
        phase_d    = phase_q;
        tx_d       = tx_q;
        rx_d       = rx_q;
        x_d        = x_q;
        y_d        = y_q;
        z_d        = z_q;
        dv_d       = 1'b0;
        init_d     = init_q;
        start      = 1'b0;
        start_word = '0;
        last_phase = (state_q == StRd) ? RdLastPhase : WrLastPhase;

        if (cs_n_q) begin
            cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 32'd1;
            case (state_q)
                StStartup: begin
                    if (cnt_q >= StartLast) begin
                        state_d    = StWrPwr;
                        start      = 1'b1;
                        start_word = {2'b00, 6'h2D, 8'h08};
                    end
                end
                StWrFmt: begin
                    if (cnt_q >= DivLast) begin
                        start      = 1'b1;
                        start_word = {2'b00, 6'h31, 8'h08};
                    end
                end
                StIdle: begin
                    if (cnt_q >= DivLast && timer_q >= PeriodLast) begin
                        state_d    = StRd;
                        start      = 1'b1;
                        start_word = {8'hF2, 8'h00};
                        timer_d    = '0;
                    end
                end
                default: ;
            endcase
        end else if (div_q >= DivLast) begin
            div_d   = '0;
            phase_d = phase_q + 7'd1;
            if (phase_q == last_phase) begin
                cs_n_d = 1'b1;
                cnt_d  = '0;
                case (state_q)
                    StWrPwr: state_d = StWrFmt;
                    StWrFmt: begin
                        state_d = StIdle;
                        init_d  = 1'b1;
                        // First read follows init after only the minimum CS-high time.
                        timer_d = PeriodLast;
                    end
                    StRd: begin
                        state_d = StIdle;
                        dv_d    = 1'b1;
                        x_d     = {rx_q[39:32], rx_q[47:40]};
                        y_d     = {rx_q[23:16], rx_q[31:24]};
                        z_d     = {rx_q[7:0], rx_q[15:8]};
                    end
                    default: ;
                endcase
            end else if (phase_q[0]) begin
                sclk_d = 1'b1;
                rx_d   = {rx_q[46:0], spi_sdo};
            end else if (phase_q != last_phase - 7'd1) begin
                sclk_d = 1'b0;
                sdi_d  = tx_q[15];
                tx_d   = {tx_q[14:0], 1'b0};
            end
        end else begin
            div_d = div_q + 32'd1;
        end

        if (start) begin
            cs_n_d  = 1'b0;
            div_d   = '0;
            phase_d = '0;
            tx_d    = start_word;
        end
    end

    always_ff @(posedge MAX10_CLK1_50) begin
        if (!rst_n) begin
            state_q <= StStartup;
            cs_n_q  <= 1'b1;
            sclk_q  <= 1'b1;
            sdi_q   <= 1'b0;
            cnt_q   <= '0;
            timer_q <= '0;
            div_q   <= '0;
            phase_q <= '0;
            tx_q    <= '0;
            rx_q    <= '0;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            dv_q    <= 1'b0;
            init_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cs_n_q  <= cs_n_d;
            sclk_q  <= sclk_d;
            sdi_q   <= sdi_d;
            cnt_q   <= cnt_d;
            timer_q <= timer_d;
            div_q   <= div_d;
            phase_q <= phase_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            x_q     <= x_d;
            y_q     <= y_d;
            z_q     <= z_d;
            dv_q    <= dv_d;
            init_q  <= init_d;
        end
    end

    assign spi_cs_n   = cs_n_q;
    assign spi_sclk   = sclk_q;
    assign spi_sdi    = sdi_q;
    assign accel_x    = x_q;
    assign accel_y    = y_q;
    assign accel_z    = z_q;
    assign data_valid = dv_q;
    assign init_done  = init_q;
    assign busy       = !cs_n_q;

endmodule
